cdc_req_sender: RTL and testbench

Source-side (clk1-domain) half of the four-phase request/acknowledge crossing into clk2. It accepts a data word with a valid/ready handshake and holds it stable on `data_out`. It raises `req_out`, which the downstream two-flop level synchronizer carries into clk2. It then waits for the returned `ack_in`, synchronized internally, to complete the full four-phase cycle before it accepts the next word.

---
 rtl/cdc_pkg.sv | 19 +
 rtl/sync_2ff.sv | 25 ++
 rtl/cdc_req_sender.sv | 118 +++++++++++
 tb/tb_cdc_req_sender.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cdc_pkg.sv
// Shared types and defaults for the clk1->clk2 four-phase request/acknowledge crossing.
// Holds the sender state encoding and the timeout counter width helper.
package cdc_pkg;

  localparam int unsigned CDC_DATA_W  = 8;
  localparam int unsigned CDC_TIMEOUT = 255;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    REQ  = 2'b01,
    REL  = 2'b10
  } cdc_req_state_t;

  // Width able to hold 0..t; never below one bit so TIMEOUT=0 still elaborates.
  function automatic int unsigned cdc_cnt_w(input int unsigned t);
    return (t < 32'd2) ? 32'd1 : 32'($clog2(t + 32'd1));
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Single-bit two-flop level synchronizer; two destination-clock cycles of latency.
// No backpressure: it samples every cycle and both flops reset to 0.
module sync_2ff (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/cdc_req_sender.sv
// clk1-side four-phase sender: accepts a word, holds it on data_out, runs req/ack to completion.
// req_out follows the accept edge; in_ready is low for the whole handshake and while the synced ack is high.
module cdc_req_sender
  import cdc_pkg::*;
#(
  parameter int unsigned DATA_W  = CDC_DATA_W,
  parameter int unsigned TIMEOUT = CDC_TIMEOUT
) (
  input  logic              clk1,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              req_out,
  output logic [DATA_W-1:0] data_out,
  input  logic              ack_in,
  output logic              busy,
  output logic              done,
  output logic              err_timeout
);

  localparam int unsigned      CNT_W   = cdc_cnt_w(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT);

  cdc_req_state_t    state_q, state_d;
  logic              req_q, req_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              ack_s;
  logic              waiting;

  sync_2ff u_ack_sync (
    .clk (clk1),
    .rst (rst),
    .d   (ack_in),
    .q   (ack_s)
  );

  always_comb begin
    state_d  = state_q;
    req_d    = req_q;
    data_d   = data_q;
    done_d   = 1'b0;
    in_ready = 1'b0;
    case (state_q)
      IDLE: begin
        in_ready = !ack_s;
        req_d    = 1'b0;
        if (in_valid && !ack_s) begin
          data_d  = in_data;
          req_d   = 1'b1;
          state_d = REQ;
        end
      end
      REQ: begin
        req_d = 1'b1;
        if (ack_s) begin
          req_d   = 1'b0;
          state_d = REL;
        end
      end
      REL: begin
        req_d = 1'b0;
        if (!ack_s) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: begin
        req_d   = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  // The counter only flags a stuck phase; req_out is never dropped early.
  assign waiting = (state_q == REQ) || (state_q == REL);

  always_comb begin
    cnt_d = cnt_q;
    err_d = err_q;
    if (state_d != state_q) begin
      cnt_d = '0;
    end else if (waiting && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + 1'b1;
    end
    if ((TIMEOUT != 0) && waiting && (state_d == state_q) && (cnt_d == CNT_MAX)) begin
      err_d = 1'b1;
    end
  end

  always_ff @(posedge clk1 or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      req_q   <= 1'b0;
      data_q  <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      data_q  <= data_d;
      done_q  <= done_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  assign req_out     = req_q;
  assign data_out    = data_q;
  assign done        = done_q;
  assign err_timeout = err_q;
  assign busy        = (state_q != IDLE);

endmodule

// File: tb/tb_cdc_req_sender.sv
// Directed and randomized bench for cdc_req_sender against a transaction/timing-rule model.
module tb_cdc_req_sender;

  localparam int TMO = 8;

  logic       clk1 = 1'b0;
  logic       rst;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_ready;
  logic       req_out;
  logic [7:0] data_out;
  logic       ack_in;
  logic       busy;
  logic       done;
  logic       err_timeout;

  always #5 clk1 = ~clk1;

  cdc_req_sender #(.DATA_W(8), .TIMEOUT(TMO)) dut (
    .clk1        (clk1),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_data     (in_data),
    .in_ready    (in_ready),
    .req_out     (req_out),
    .data_out    (data_out),
    .ack_in      (ack_in),
    .busy        (busy),
    .done        (done),
    .err_timeout (err_timeout)
  );

  int n_chk = 0;
  int n_err = 0;
  int cyc = 0;

  // Reference model: handshake phase, held word and event times derived from the timing rules.
  logic       m_busy, m_req, m_err, m_ready, a1, a2, prev_req;
  logic [7:0] m_data;
  int         req_fall_at, done_at, phase_start;
  int         n_acc, n_done, n_rr, last_acc_cyc, last_done_cyc;
  logic [7:0] pending[$];

  logic auto_rem;
  int   dly_hi, dly_lo, rcnt, fcnt;

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%b expected=%b cycle=%0d", tag, obs, exp, cyc);
    end
  endtask

  task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%h expected=%h cycle=%0d", tag, obs, exp, cyc);
    end
  endtask

  task automatic chki(input string tag, input int obs, input int exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0d expected=%0d cycle=%0d", tag, obs, exp, cyc);
    end
  endtask

  task automatic model_reset();
    m_busy = 1'b0; m_req = 1'b0; m_err = 1'b0; m_ready = 1'b1;
    a1 = 1'b0; a2 = 1'b0; prev_req = 1'b0; m_data = 8'h00;
    req_fall_at = -1; done_at = -1; phase_start = 0;
    rcnt = 0; fcnt = 0;
    ack_in = 1'b0;
    pending.delete();
  endtask

  // Remote side drives ack_in; the model derives req-fall and done times from each change.
  task automatic set_ack(input logic v);
    if (v && !ack_in && m_req && req_fall_at < 0) req_fall_at = cyc + 3;
    if (!v && ack_in && m_busy && !m_req) done_at = cyc + 3;
    ack_in = v;
  endtask

  task automatic step();
    logic       acc;
    logic [7:0] w;
    logic       pre_ack;
    logic       exp_done;
    acc     = in_valid && m_ready;
    w       = in_data;
    pre_ack = ack_in;
    @(posedge clk1);
    #1;
    cyc++;
    if (cyc == req_fall_at) begin
      m_req = 1'b0; phase_start = cyc; req_fall_at = -1;
    end
    exp_done = (cyc == done_at);
    if (exp_done) begin
      m_busy = 1'b0; done_at = -1; n_done++; last_done_cyc = cyc;
    end
    if (acc) begin
      m_busy = 1'b1; m_req = 1'b1; m_data = w; phase_start = cyc;
      n_acc++; last_acc_cyc = cyc; pending.push_back(w);
    end
    a2 = a1;
    a1 = pre_ack;
    if (m_busy && (cyc - phase_start) >= TMO) m_err = 1'b1;
    m_ready = !m_busy && !a2;
    if (req_out && !prev_req) n_rr++;
    prev_req = req_out;

    chk1("req_out", req_out, m_req);
    chk1("busy", busy, m_busy);
    chk1("in_ready", in_ready, m_ready);
    chk1("done", done, exp_done);
    chk8("data_out", data_out, m_data);
    chk1("err_timeout", err_timeout, m_err);
    if (exp_done) begin
      chk1("done_has_word", pending.size() != 0, 1'b1);
      if (pending.size() != 0) chk8("done_word", data_out, pending.pop_front());
    end

    if (auto_rem) begin
      if (req_out && !ack_in) begin
        rcnt++;
        if (rcnt >= dly_hi) begin set_ack(1'b1); rcnt = 0; end
      end else if (!req_out && ack_in && m_busy) begin
        fcnt++;
        if (fcnt >= dly_lo) begin set_ack(1'b0); fcnt = 0; end
      end
    end
  endtask

  task automatic wait_idle(input int maxc);
    int k = 0;
    while ((m_busy || ack_in) && k < maxc) begin
      step();
      k++;
    end
    chk1("idle_within_bound", k < maxc, 1'b1);
  endtask

  task automatic wait_accept(input int maxc);
    int k = 0;
    int start = n_acc;
    while (n_acc == start && k < maxc) begin
      step();
      k++;
    end
    chk1("accept_within_bound", n_acc != start, 1'b1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, cycle=%0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int d0, r0, k;
    n_acc = 0; n_done = 0; n_rr = 0; last_acc_cyc = 0; last_done_cyc = 0;
    auto_rem = 1'b0; dly_hi = 4; dly_lo = 4;
    rst = 1'b0; in_valid = 1'b0; in_data = 8'h00;
    model_reset();

    // Reset values while reset is held.
    #3;
    chk1("rst_req_out", req_out, 1'b0);
    chk8("rst_data_out", data_out, 8'h00);
    chk1("rst_in_ready", in_ready, 1'b1);
    chk1("rst_busy", busy, 1'b0);
    chk1("rst_done", done, 1'b0);
    chk1("rst_err", err_timeout, 1'b0);
    @(posedge clk1);
    #3;
    rst = 1'b1;

    // Single transfer, remote answers after 4 cycles each way.
    auto_rem = 1'b1; dly_hi = 4; dly_lo = 4;
    d0 = n_done;
    in_valid = 1'b1; in_data = 8'hA5;
    step();
    in_valid = 1'b0; in_data = 8'h00;
    wait_idle(60);
    chki("t1_done_count", n_done - d0, 1);
    chki("t1_accept_to_done", last_done_cyc - last_acc_cyc, 12);
    chk8("t1_data_held", data_out, 8'hA5);

    // Back-to-back words with in_valid held high.
    d0 = n_done;
    in_valid = 1'b1;
    for (int w = 1; w <= 3; w++) begin
      in_data = 8'(w);
      wait_accept(60);
      if (w > 1) chki("t2_accept_in_done_cycle", last_acc_cyc, last_done_cyc + 1);
    end
    in_valid = 1'b0;
    wait_idle(60);
    chki("t2_done_count", n_done - d0, 3);

    // in_valid/in_data toggled throughout REQ and REL.
    dly_hi = $urandom_range(1, 6); dly_lo = $urandom_range(1, 6);
    r0 = n_rr;
    in_valid = 1'b1; in_data = 8'h5A;
    step();
    k = 0;
    while (m_busy && k < 60) begin
      in_valid = 1'($urandom_range(0, 1));
      in_data  = 8'($urandom);
      step();
      k++;
    end
    in_valid = 1'b0;
    chk1("t3_completed", k < 60, 1'b1);
    chki("t3_req_pulses", n_rr - r0, 1);
    chk8("t3_data_held", data_out, 8'h5A);

    // Randomized traffic, delays kept below the timeout.
    d0 = n_done;
    for (int t = 0; t < 20; t++) begin
      dly_hi = $urandom_range(1, 6); dly_lo = $urandom_range(1, 6);
      repeat ($urandom_range(0, 3)) begin
        in_data = 8'($urandom);
        step();
      end
      in_valid = 1'b1; in_data = 8'($urandom);
      wait_accept(60);
      in_valid = 1'b0;
      wait_idle(60);
    end
    chki("t4_done_count", n_done - d0, 20);

    // Remote never answers: timeout flag sets but the request is held.
    auto_rem = 1'b0;
    d0 = n_done;
    in_valid = 1'b1; in_data = 8'hC3;
    step();
    in_valid = 1'b0;
    repeat (12) step();
    chk1("t5_err_set", err_timeout, 1'b1);
    chk1("t5_req_held", req_out, 1'b1);
    auto_rem = 1'b1; dly_hi = 2; dly_lo = 2;
    wait_idle(60);
    chki("t5_late_done", n_done - d0, 1);
    chk1("t5_err_sticky", err_timeout, 1'b1);

    // Asynchronous reset in the middle of REQ.
    auto_rem = 1'b0;
    in_valid = 1'b1; in_data = 8'h3C;
    step();
    in_valid = 1'b0;
    step();
    #3;
    rst = 1'b0;
    #1;
    chk1("t6_req_async", req_out, 1'b0);
    chk1("t6_busy_async", busy, 1'b0);
    chk8("t6_data_async", data_out, 8'h00);
    chk1("t6_err_async", err_timeout, 1'b0);
    model_reset();
    #1;
    rst = 1'b1;
    step();
    chk1("t6_idle_ready", in_ready, 1'b1);

    // Stale ack high when reset is released.
    #3;
    rst = 1'b0;
    model_reset();
    ack_in = 1'b1;
    #1;
    rst = 1'b1;
    step();
    chk1("t7_ready_first", in_ready, 1'b1);
    step();
    chk1("t7_ready_low", in_ready, 1'b0);
    d0 = n_acc;
    in_valid = 1'b1; in_data = 8'h99;
    repeat (3) step();
    chki("t7_no_accept", n_acc - d0, 0);
    set_ack(1'b0);
    k = cyc;
    wait_accept(10);
    chki("t7_accept_edge", last_acc_cyc, k + 3);
    in_valid = 1'b0;
    auto_rem = 1'b1; dly_hi = 3; dly_lo = 3;
    wait_idle(60);
    chk8("t7_data_held", data_out, 8'h99);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
